// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_isa_pkg
// Description : Shared ISA definitions for the decode stage, FSM and ALU:
//               opcode encodings, RUN/HALT state encoding and small
//               classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_isa_pkg;

  // Number of opcode bits the ISA actually encodes.
  localparam int ISA_OPC_W = 4;

  localparam logic [ISA_OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [ISA_OPC_W-1:0] OPC_ADD  = 4'h1;
  localparam logic [ISA_OPC_W-1:0] OPC_SUB  = 4'h2;
  localparam logic [ISA_OPC_W-1:0] OPC_ORR  = 4'h3;
  localparam logic [ISA_OPC_W-1:0] OPC_XORR = 4'h4;
  localparam logic [ISA_OPC_W-1:0] OPC_LD   = 4'h5;
  localparam logic [ISA_OPC_W-1:0] OPC_ST   = 4'h6;
  localparam logic [ISA_OPC_W-1:0] OPC_JMP  = 4'h7;
  localparam logic [ISA_OPC_W-1:0] OPC_BEQ  = 4'h8;
  localparam logic [ISA_OPC_W-1:0] OPC_LDI  = 4'h9;
  localparam logic [ISA_OPC_W-1:0] OPC_NOTI = 4'hA;
  localparam logic [ISA_OPC_W-1:0] OPC_HLT  = 4'hB;

  // Fetch control state: RUN accepts instructions, HALT blocks fetch.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Encodings above HLT are unassigned.
  function automatic logic opc_is_legal(input logic [ISA_OPC_W-1:0] opc);
    return (opc <= OPC_HLT);
  endfunction

  // Instructions that produce a register-file write to rd.
  function automatic logic opc_writes_rd(input logic [ISA_OPC_W-1:0] opc);
    logic r;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_ORR, OPC_XORR,
      OPC_LD, OPC_LDI, OPC_NOTI: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_split.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_split
// Description : Purely combinational instruction field extraction and
//               classification. Splits the word into opcode, rd, rs1, rs2
//               and immediate; flags illegal opcodes (forcing the emitted
//               opcode to NOP), register writes and HLT.
// Ports       : instr_i      - instruction word
//               opcode_o     - opcode, NOP when illegal
//               rd_o/rs1_o/rs2_o - register index fields
//               imm_o        - immediate (low IMM_W bits, may overlap regs)
//               writes_rd_o  - instruction writes rd
//               illegal_o    - opcode outside the defined set
//               is_hlt_o     - instruction is HLT
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_split
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 3,
  parameter int IMM_W   = 8
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [REG_W-1:0]   rd_o,
  output logic [REG_W-1:0]   rs1_o,
  output logic [REG_W-1:0]   rs2_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic               writes_rd_o,
  output logic               illegal_o,
  output logic               is_hlt_o
);

  // Register fields sit directly below the opcode, MSB first.
  localparam int RD_MSB  = INSTR_W - OPC_W - 1;
  localparam int RS1_MSB = RD_MSB - REG_W;
  localparam int RS2_MSB = RS1_MSB - REG_W;

  logic [OPC_W-1:0]     w_opc_raw;
  logic [ISA_OPC_W-1:0] w_opc_isa;
  logic                 w_opc_hi_zero;
  logic                 w_legal;

  assign w_opc_raw = instr_i[INSTR_W-1 -: OPC_W];
  assign w_opc_isa = w_opc_raw[ISA_OPC_W-1:0];

  // A wider opcode field is only legal when its unused top bits are zero.
  generate
    if (OPC_W > ISA_OPC_W) begin : g_wide_opc
      assign w_opc_hi_zero = ~|w_opc_raw[OPC_W-1:ISA_OPC_W];
    end else begin : g_isa_opc
      assign w_opc_hi_zero = 1'b1;
    end
  endgenerate

  assign w_legal = w_opc_hi_zero & opc_is_legal(w_opc_isa);

  assign opcode_o    = w_legal ? w_opc_raw : '0;
  assign rd_o        = instr_i[RD_MSB  -: REG_W];
  assign rs1_o       = instr_i[RS1_MSB -: REG_W];
  assign rs2_o       = instr_i[RS2_MSB -: REG_W];
  assign imm_o       = instr_i[IMM_W-1:0];
  assign writes_rd_o = w_legal & opc_writes_rd(w_opc_isa);
  assign illegal_o   = ~w_legal;
  assign is_hlt_o    = w_legal & (w_opc_isa == OPC_HLT);

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered instruction-decode pipeline stage. Accepts one
//               instruction per valid/ready handshake, decodes it through
//               instr_field_split and presents the result one cycle later.
//               A RUN/HALT FSM stops fetch after HLT until resume, and a
//               saturating counter tracks accepted illegal opcodes.
// Config      : DECODE_ILLEGAL_TRAP_EN - when defined, an accepted illegal
//               opcode also halts the stage, exactly like HLT.
// Ports       : clk, rst                 - clock, sync active-high reset
//               in_valid/in_ready/in_instr - fetch-side handshake
//               out_valid/out_ready      - decode-side handshake
//               out_opcode/out_rd/out_rs1/out_rs2/out_imm - decoded fields
//               out_writes_rd/out_illegal - classification flags
//               flush                    - drop held entry, block accept
//               resume                   - leave HALT
//               halted                   - FSM is in HALT
//               illegal_count            - saturating illegal-opcode count
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 3,
  parameter int IMM_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_writes_rd,
  output logic               out_illegal,
  input  logic               flush,
  input  logic               resume,
  output logic               halted,
  output logic [CNT_W-1:0]   illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Decoded view of the incoming word.
  logic [OPC_W-1:0] w_opcode;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic [IMM_W-1:0] w_imm;
  logic             w_writes_rd;
  logic             w_illegal;
  logic             w_is_hlt;

  logic             w_accept;
  logic             w_halt_req;

  // Output register.
  logic             out_valid_q;
  logic [OPC_W-1:0] opcode_q;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] rs1_q;
  logic [REG_W-1:0] rs2_q;
  logic [IMM_W-1:0] imm_q;
  logic             writes_rd_q;
  logic             illegal_q;

  // FSM and counter.
  run_state_e       state_q;
  run_state_e       state_d;
  logic             halted_q;
  logic [CNT_W-1:0] illegal_count_q;
  logic [CNT_W-1:0] illegal_count_d;

  instr_field_split #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .REG_W   (REG_W),
    .IMM_W   (IMM_W)
  ) u_field_split (
    .instr_i     (in_instr),
    .opcode_o    (w_opcode),
    .rd_o        (w_rd),
    .rs1_o       (w_rs1),
    .rs2_o       (w_rs2),
    .imm_o       (w_imm),
    .writes_rd_o (w_writes_rd),
    .illegal_o   (w_illegal),
    .is_hlt_o    (w_is_hlt)
  );

  // Ready depends only on registered state and the downstream/flush inputs,
  // never on in_valid or in_instr.
  assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready) & ~flush;
  assign w_accept = in_valid & in_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Illegal opcodes trap into HALT the same way HLT does.
  assign w_halt_req = w_accept & (w_is_hlt | w_illegal);
`else
  assign w_halt_req = w_accept & w_is_hlt;
`endif

  // --------------------------------------------------------------------------
  // Output register: flush wins over accept (in_ready is already low then),
  // then load on accept, otherwise drain when downstream takes the entry.
  // Fields hold whenever nothing is loaded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      writes_rd_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      opcode_q    <= w_opcode;
      rd_q        <= w_rd;
      rs1_q       <= w_rs1;
      rs2_q       <= w_rs2;
      imm_q       <= w_imm;
      writes_rd_q <= w_writes_rd;
      illegal_q   <= w_illegal;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // RUN/HALT FSM. Accept is impossible in HALT, so a HLT accepted alongside
  // resume (only possible in RUN) always ends in HALT.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (w_halt_req) state_d = ST_HALT;
      ST_HALT: if (resume)     state_d = ST_RUN;
      default:                 state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // --------------------------------------------------------------------------
  // Saturating illegal-opcode counter, stepped on accept only.
  // --------------------------------------------------------------------------
  always_comb begin
    illegal_count_d = illegal_count_q;
    if (w_accept && w_illegal && (illegal_count_q != CNT_MAX)) begin
      illegal_count_d = illegal_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count_q <= '0;
    end else begin
      illegal_count_q <= illegal_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = opcode_q;
  assign out_rd        = rd_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_imm       = imm_q;
  assign out_writes_rd = writes_rd_q;
  assign out_illegal   = illegal_q;
  assign halted        = halted_q;
  assign illegal_count = illegal_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode_stage
// Description : Self-checking bench for instr_decode_stage: a table of
//               hand-decoded vectors, directed handshake/FSM/counter
//               sequences and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [2:0]  out_rs1;
  logic [2:0]  out_rs2;
  logic [7:0]  out_imm;
  logic        out_writes_rd;
  logic        out_illegal;
  logic        flush;
  logic        resume;
  logic        halted;
  logic [7:0]  illegal_count;

  instr_decode_stage #(
    .INSTR_W (16), .OPC_W (4), .REG_W (3), .IMM_W (8), .CNT_W (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_writes_rd (out_writes_rd),
    .out_illegal   (out_illegal),
    .flush         (flush),
    .resume        (resume),
    .halted        (halted),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_accepts = 0;

  // Behavioural model state.
  bit         m_valid;
  bit         m_halt;
  logic [3:0] m_opc;
  logic [2:0] m_rd, m_rs1, m_rs2;
  logic [7:0] m_imm;
  bit         m_wr, m_ill;
  int         m_cnt;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  opc;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm;
    bit          wr, ill;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_halt = 0; m_opc = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_imm = '0; m_wr = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic compare_all();
    check("out_valid",     32'(out_valid),     32'(m_valid));
    check("out_opcode",    32'(out_opcode),    32'(m_opc));
    check("out_rd",        32'(out_rd),        32'(m_rd));
    check("out_rs1",       32'(out_rs1),       32'(m_rs1));
    check("out_rs2",       32'(out_rs2),       32'(m_rs2));
    check("out_imm",       32'(out_imm),       32'(m_imm));
    check("out_writes_rd", 32'(out_writes_rd), 32'(m_wr));
    check("out_illegal",   32'(out_illegal),   32'(m_ill));
    check("halted",        32'(halted),        32'(m_halt));
    check("illegal_count", 32'(illegal_count), 32'(m_cnt));
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model across
  // the edge and compare every registered output.
  task automatic cyc(input bit r, input bit v, input logic [15:0] ins,
                     input bit rdy, input bit fl, input bit rs);
    bit exp_rdy, acc, ill;
    int op;
    rst = r; in_valid = v; in_instr = ins; out_ready = rdy; flush = fl; resume = rs;
    #1;
    exp_rdy = !m_halt && (!m_valid || rdy) && !fl;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy && !r;
    op  = int'(ins[15:12]);
    ill = (op > 11);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (acc) n_accepts++;
      if (m_halt) begin
        if (rs) m_halt = 0;
      end else if (acc && (op == 11 || (TRAP_EN && ill))) begin
        m_halt = 1;
      end
      if (acc && ill && m_cnt < 255) m_cnt++;
      if (fl) begin
        m_valid = 0;
      end else if (acc) begin
        m_valid = 1;
        m_opc   = ill ? 4'h0 : op[3:0];
        m_rd    = ins[11:9];
        m_rs1   = ins[8:6];
        m_rs2   = ins[5:3];
        m_imm   = ins[7:0];
        m_wr    = (op inside {1, 2, 3, 4, 5, 9, 10});
        m_ill   = ill;
      end else if (rdy) begin
        m_valid = 0;
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] imm_hold;
    int         start_acc;

    vecs[0] = '{16'h1234, 4'h1, 3'd1, 3'd0, 3'd6, 8'h34, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{16'h2ABC, 4'h2, 3'd5, 3'd2, 3'd7, 8'hBC, 1'b1, 1'b0};
    vecs[3] = '{16'h6FFF, 4'h6, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{16'h9E5A, 4'h9, 3'd7, 3'd1, 3'd3, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{16'hA123, 4'hA, 3'd0, 3'd4, 3'd4, 8'h23, 1'b1, 1'b0};
    vecs[6] = '{16'h7080, 4'h7, 3'd0, 3'd2, 3'd0, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{16'h5C00, 4'h5, 3'd6, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{16'hD555, 4'h0, 3'd2, 3'd5, 3'd2, 8'h55, 1'b0, 1'b1};

    rst = 1; in_valid = 0; in_instr = '0; out_ready = 0; flush = 0; resume = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset state.
    cyc(1, 0, 16'h0, 0, 0, 0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(illegal_count), 32'd0);
    check("rst_halted",    32'(halted), 32'd0);

    // Table-driven decode, back-to-back with out_ready high.
    foreach (vecs[i]) begin
      cyc(0, 1, vecs[i].instr, 1, 0, 0);
      check("vec_valid", 32'(out_valid),     32'd1);
      check("vec_opc",   32'(out_opcode),    32'(vecs[i].opc));
      check("vec_rd",    32'(out_rd),        32'(vecs[i].rd));
      check("vec_rs1",   32'(out_rs1),       32'(vecs[i].rs1));
      check("vec_rs2",   32'(out_rs2),       32'(vecs[i].rs2));
      check("vec_imm",   32'(out_imm),       32'(vecs[i].imm));
      check("vec_wr",    32'(out_writes_rd), 32'(vecs[i].wr));
      check("vec_ill",   32'(out_illegal),   32'(vecs[i].ill));
    end
    check("vec_trap_halt", 32'(halted), 32'(TRAP_EN));
    cyc(0, 0, 16'h0, 1, 0, 1);

    // Backpressure: held entry stays stable, release accepts immediately.
    cyc(0, 1, 16'h1234, 1, 0, 0);
    imm_hold = out_imm;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 16'h2ABC, 0, 0, 0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_imm_hold", 32'(out_imm), 32'(imm_hold));
    end
    cyc(0, 1, 16'h2ABC, 1, 0, 0);
    check("bp_release_imm", 32'(out_imm), 32'h0BC);

    // HLT is emitted and halts; in_ready then low.
    cyc(0, 1, 16'hB000, 1, 0, 0);
    check("hlt_emit_opc", 32'(out_opcode), 32'hB);
    check("hlt_halted",   32'(halted), 32'd1);
    cyc(0, 1, 16'h1234, 1, 0, 0);
    check("hlt_in_ready", 32'(in_ready), 32'd0);
    // Resume alone leaves HALT.
    cyc(0, 0, 16'h0, 1, 0, 1);
    check("resume_halted", 32'(halted), 32'd0);
    // HLT accepted together with resume: HALT wins.
    cyc(0, 1, 16'hB000, 1, 0, 1);
    check("hlt_resume_halted", 32'(halted), 32'd1);
    cyc(0, 0, 16'h0, 1, 0, 1);
    check("resume2_halted", 32'(halted), 32'd0);

    // Illegal opcode stream: saturation at 255 (trap build halts each time).
    start_acc = n_accepts;
    cyc(0, 1, 16'hF000, 1, 0, 0);
    check("ill_first_nop",  32'(out_opcode), 32'd0);
    check("ill_first_flag", 32'(out_illegal), 32'd1);
    check("ill_first_halt", 32'(halted), 32'(TRAP_EN));
    for (int i = 0; i < 700 && (n_accepts - start_acc) < 260; i++) begin
      cyc(0, 1, 16'hF000, 1, 0, m_halt);
    end
    check("ill_accepts", 32'(n_accepts - start_acc), 32'd260);
    check("ill_saturate", 32'(illegal_count), 32'd255);
    cyc(0, 0, 16'h0, 1, 0, 1);

    // Flush with a held entry and a pending instruction.
    cyc(0, 1, 16'h1234, 1, 0, 0);
    cyc(0, 1, 16'h2ABC, 1, 1, 0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_no_acc", 32'(out_imm), 32'h034);

    // Reset mid-stream.
    cyc(0, 1, 16'h9E5A, 1, 0, 0);
    cyc(1, 1, 16'hB000, 1, 0, 0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_imm",   32'(out_imm), 32'd0);
    check("mrst_count", 32'(illegal_count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, 16'($urandom),
          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, parametrised instruction-decode pipeline stage between the instruction register/fetch path and the FSM/ALU/register file. Accepts one instruction word per valid/ready handshake, splits it into opcode, destination, two source-register indices and an immediate, classifies it (register write, legal/illegal), and presents the result one cycle later on a valid/ready output port. It has a RUN/HALT state machine that stops fetch after HLT until `resume`, and a saturating illegal-opcode counter.

## Interface
- `INSTR_W`, 16: instruction width.
- `OPC_W`, 4: opcode field width, bits [INSTR_W-1 -: OPC_W].
- `REG_W`, 3: register index width. rd, rs1 and rs2 occupy the next three REG_W-bit fields below the opcode.
- `IMM_W`, 8: immediate width, bits [IMM_W-1:0]. May overlap the register fields.
- `CNT_W`, 8: illegal counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1 / `in_instr` in INSTR_W: fetch side.
- `out_valid` out 1 / `out_ready` in 1: decode side.
- `out_opcode` out OPC_W; `out_rd`, `out_rs1`, `out_rs2` out REG_W; `out_imm` out IMM_W.
- `out_writes_rd` out 1: instruction writes rd.
- `out_illegal` out 1: opcode is outside the defined set.
- `flush` in 1: drops the held entry, for taken JMP/BEQ.
- `resume` in 1: leaves HALT.
- `halted` out 1: state == HALT.
- `illegal_count` out CNT_W: saturating count of illegal opcodes accepted.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, ORR=3, XORR=4, LD=5, ST=6, JMP=7, BEQ=8, LDI=9, NOTI=A, HLT=B. Values C–F are illegal.
- `out_writes_rd`=1 for ADD, SUB, ORR, XORR, LD, LDI and NOTI. It is 0 for all other opcodes and for illegal ones.
- Illegal opcode: `out_opcode` is forced to NOP, `out_illegal`=1, and the register and immediate fields pass through unchanged. `illegal_count` increments on accept and saturates at all-ones.
- Accept: an instruction is accepted when `in_valid && in_ready`. `in_ready` = (state==RUN) && (!out_valid || out_ready) && !flush.
- Output register: loads on accept. `out_valid` clears when `out_ready` is high and nothing is accepted that cycle. Output fields hold while `out_valid && !out_ready`.
- FSM RUN→HALT: on the cycle a HLT is accepted. The HLT itself is still emitted downstream.
- FSM HALT→RUN: when `resume`=1. `resume` is ignored in RUN.
- Simultaneous HLT accept and `resume`: the result is HALT.
- Flush: `out_valid` becomes 0 next cycle. No accept happens in a flush cycle. FSM state and `illegal_count` are unchanged. In HALT, `flush` does not resume.
- Reset mid-operation: all state returns to reset values on the next edge. Any held entry is discarded.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Back-to-back throughput is 1 per cycle while `out_ready`=1.
- `in_ready` is combinational from state, `out_valid`, `out_ready` and `flush`. There is no combinational path from `in_valid`/`in_instr` to any output.
- Reset values: `out_valid`=0, all output fields=0, `out_illegal`=0, `out_writes_rd`=0, state=RUN, `halted`=0, `illegal_count`=0. `in_ready` follows from these values (=1 unless `flush` is high).
- `halted` rises the cycle after HLT is accepted. `in_ready` is 0 from that cycle.
- After a `resume` edge, `in_ready` may be 1 the following cycle.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - An accepted illegal opcode also moves the FSM to HALT, exactly as HLT does.
  - `halted` then stays high until `resume`.
- Undefined:
  - Illegal opcodes are emitted as flagged NOPs.
  - Fetch continues.
- `illegal_count` and `out_illegal` behave the same in both builds.

## Structure
- Package `cpu_isa_pkg` holds the opcode localparams and the RUN/HALT state encoding. The FSM and ALU import the same package.
- Sub-module `instr_field_split`: purely combinational field extraction and classification (opcode legality, writes_rd). It is instantiated once. Handshake, FSM and counter logic stay in `instr_decode_stage`.

## Test plan
- Reset, then accept 0x1234 (ADD, rd=1, rs1=0, rs2=6, imm=0x34) with `out_ready`=1 → one cycle later `out_valid`=1, `out_opcode`=1, `out_writes_rd`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and output fields stable. Release → next instruction is accepted that same cycle.
- HLT 0xB000 accepted → emitted downstream, `halted`=1 next cycle, `in_ready`=0.
- Assert `resume` and a new HLT together → stays halted.
- Assert `resume` alone → `halted`=0 next cycle.
- 260 accepts of 0xF000 → each emitted as NOP with `out_illegal`=1, and `illegal_count` stops at 255.
  - With `DECODE_ILLEGAL_TRAP_EN` defined, the first one halts instead.
- `flush` with `out_valid`=1 and `in_valid`=1 → `out_valid`=0 next cycle, instruction not accepted. Assert `rst` mid-stream → all outputs reset next cycle.
